serial_add_ctrl: RTL and testbench

Bit-serial adder controller that time-multiplexes one 1-bit full_adder cell across a WIDTH-bit addition, LSB first.
- Holds operands in shift registers and the carry in a flip-flop.
- A small FSM sequences the cell for WIDTH cycles, then presents the registered result with a done pulse.
- Sits between board-level operand capture (switches or registers) and the display/result logic on the Basys3 lab design.

---
 rtl/serial_add_pkg.sv | 11 +
 rtl/full_adder.sv | 11 +
 rtl/serial_add_ctrl.sv | 82 ++++++++
 tb/tb_serial_add_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encoding and counter-width helper shared by the serial adder.
package serial_add_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: 1-bit combinational full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder, LSB first, one full_adder reused per cycle.
// Define SERIAL_ADD_OVF_EN to add a registered two's-complement overflow output.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             overflow,
`endif
  output logic             cout
);
  localparam int CW = clog2_min1(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, acc_q, sum_q, acc_d;
  logic [CW-1:0] cnt_q;
  logic carry_q, cout_q, fa_s, fa_co, last;
  full_adder u_fa (
    .a_i   (opa_q[0]),
    .b_i   (opb_q[0]),
    .cin_i (carry_q),
    .s_o   (fa_s),
    .cout_o(fa_co)
  );
  assign last  = cnt_q == CW'(WIDTH - 1);
  assign acc_d = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  always_comb begin
    state_d = (state_q == ST_SHIFT) ? (last ? ST_DONE : ST_SHIFT)
                                    : (start ? ST_SHIFT : ST_IDLE);
  end
`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (state_q == ST_SHIFT && last) ovf_q <= carry_q ^ fa_co;
  end
  assign overflow = ovf_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_SHIFT) begin
        opa_q   <= opa_q >> 1;
        opb_q   <= opb_q >> 1;
        acc_q   <= acc_d;
        carry_q <= fa_co;
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          sum_q  <= acc_d;
          cout_q <= fa_co;
        end
      end else if (start) begin
        opa_q   <= a;
        opb_q   <= b;
        carry_q <= cin;
        cnt_q   <= '0;
      end
    end
  end
  assign busy = state_q == ST_SHIFT;
  assign done = state_q == ST_DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed checks of the serial adder at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf8, ovf1;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADD_OVF_EN
    .overflow(ovf8),
`endif
    .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1),
`ifdef SERIAL_ADD_OVF_EN
    .overflow(ovf1),
`endif
    .cout(cout1)
  );

  task automatic do_op8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        output int lat, output int bc, output logic [7:0] s,
                        output logic c, output logic ov);
    @(negedge clk);
    start8 = 1'b1; a8 = xa; b8 = xb; cin8 = xc;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    bc = 0;
    while (!done8 && lat < 40) begin
      bc += int'(busy8);
      @(negedge clk);
      lat++;
    end
    s = sum8;
    c = cout8;
`ifdef SERIAL_ADD_OVF_EN
    ov = ovf8;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 0; start1 = 0; a8 = 0; b8 = 0; cin8 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 5;
    if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy8); end
    if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done8); end
    if (sum8 !== 8'h00) begin n_bad++; $display("FAIL reset_sum got %h want 00", sum8); end
    if (cout8 !== 1'b0) begin n_bad++; $display("FAIL reset_cout got %b want 0", cout8); end
    if ({busy1, done1, sum1, cout1} !== 4'b0) begin
      n_bad++; $display("FAIL reset_w1 got %b want 0000", {busy1, done1, sum1, cout1});
    end
  endtask

  task automatic test_basic;
    int lat, bc; logic [7:0] s; logic c, ov;
    do_op8(8'h0F, 8'h01, 1'b0, lat, bc, s, c, ov);
    n_cmp += 4;
    if (lat !== 9) begin n_bad++; $display("FAIL basic_latency got %0d want 9", lat); end
    if (bc !== 8) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    if (s !== 8'h10) begin n_bad++; $display("FAIL basic_sum got %h want 10", s); end
    if (c !== 1'b0) begin n_bad++; $display("FAIL basic_cout got %b want 0", c); end
    @(negedge clk);
    n_cmp += 2;
    if (done8 !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", done8); end
    if (sum8 !== 8'h10) begin n_bad++; $display("FAIL basic_sum_hold got %h want 10", sum8); end
  endtask

  task automatic test_carry;
    int lat, bc; logic [7:0] s; logic c, ov;
    do_op8(8'hFF, 8'h01, 1'b0, lat, bc, s, c, ov);
    n_cmp += 2;
    if (s !== 8'h00) begin n_bad++; $display("FAIL carry1_sum got %h want 00", s); end
    if (c !== 1'b1) begin n_bad++; $display("FAIL carry1_cout got %b want 1", c); end
    do_op8(8'hFF, 8'hFF, 1'b1, lat, bc, s, c, ov);
    n_cmp += 2;
    if (s !== 8'hFF) begin n_bad++; $display("FAIL carry2_sum got %h want ff", s); end
    if (c !== 1'b1) begin n_bad++; $display("FAIL carry2_cout got %b want 1", c); end
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_overflow;
    int lat, bc; logic [7:0] s; logic c, ov;
    do_op8(8'h7F, 8'h01, 1'b0, lat, bc, s, c, ov);
    n_cmp += 1;
    if ({c, s, ov} !== {1'b0, 8'h80, 1'b1}) begin
      n_bad++; $display("FAIL ovf1 got c=%b s=%h ov=%b want c=0 s=80 ov=1", c, s, ov);
    end
    do_op8(8'h80, 8'h80, 1'b0, lat, bc, s, c, ov);
    n_cmp += 1;
    if ({c, s, ov} !== {1'b1, 8'h00, 1'b1}) begin
      n_bad++; $display("FAIL ovf2 got c=%b s=%h ov=%b want c=1 s=00 ov=1", c, s, ov);
    end
    do_op8(8'hFF, 8'h01, 1'b0, lat, bc, s, c, ov);
    n_cmp += 1;
    if (ov !== 1'b0) begin n_bad++; $display("FAIL ovf3 got %b want 0", ov); end
  endtask
`endif

  task automatic test_ignore_start;
    int dones = 0; int done_cyc = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 15; k++) begin
      if (done8) begin dones++; done_cyc = k; end
      start8 = (k == 3 || k == 5);
      if (k == 3 || k == 5) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
      @(negedge clk);
    end
    n_cmp += 4;
    if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", dones); end
    if (done_cyc !== 9) begin n_bad++; $display("FAIL ignore_done_cycle got %0d want 9", done_cyc); end
    if (sum8 !== 8'h96) begin n_bad++; $display("FAIL ignore_sum got %h want 96", sum8); end
    if (cout8 !== 1'b0) begin n_bad++; $display("FAIL ignore_cout got %b want 0", cout8); end
  endtask

  task automatic test_reset_mid;
    int lat, bc; logic [7:0] s; logic c, ov;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hF7; b8 = 8'h11; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp += 4;
    if (busy8 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy8); end
    if (done8 !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b want 0", done8); end
    if (sum8 !== 8'h00) begin n_bad++; $display("FAIL midrst_sum got %h want 00", sum8); end
    if (cout8 !== 1'b0) begin n_bad++; $display("FAIL midrst_cout got %b want 0", cout8); end
    do_op8(8'h12, 8'h34, 1'b0, lat, bc, s, c, ov);
    n_cmp += 2;
    if (s !== 8'h46 || c !== 1'b0) begin
      n_bad++; $display("FAIL midrst_fresh got c=%b s=%h want c=0 s=46", c, s);
    end
    if (lat !== 9) begin n_bad++; $display("FAIL midrst_latency got %0d want 9", lat); end
  endtask

  task automatic test_back_to_back8;
    logic [8:0] exp;
    int cyc;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    exp = {1'b0, a8} + {1'b0, b8} + {8'h00, cin8};
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      cyc = 1;
      while (!done8 && cyc < 20) begin @(negedge clk); cyc++; end
      n_cmp += 2;
      if (cyc !== 9) begin n_bad++; $display("FAIL b2b8_period op%0d got %0d want 9", i, cyc); end
      if ({cout8, sum8} !== exp) begin
        n_bad++; $display("FAIL b2b8_result op%0d got %h want %h", i, {cout8, sum8}, exp);
      end
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      exp = {1'b0, a8} + {1'b0, b8} + {8'h00, cin8};
      start8 = (i < 49);
      @(negedge clk);
    end
    start8 = 1'b0;
  endtask

  task automatic test_back_to_back1;
    logic [1:0] exp;
    int cyc;
    @(negedge clk);
    start1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    exp = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      cyc = 1;
      while (!done1 && cyc < 10) begin @(negedge clk); cyc++; end
      n_cmp += 2;
      if (cyc !== 2) begin n_bad++; $display("FAIL b2b1_period op%0d got %0d want 2", i, cyc); end
      if ({cout1, sum1} !== exp) begin
        n_bad++; $display("FAIL b2b1_result op%0d got %b want %b", i, {cout1, sum1}, exp);
      end
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      exp = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
      start1 = (i < 49);
      @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
`ifdef SERIAL_ADD_OVF_EN
    test_overflow();
`endif
    test_ignore_start();
    test_reset_mid();
    test_back_to_back8();
    test_back_to_back1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
